// File: rtl/bit_reversal_reorder_buf.sv
// ---------------------------------------------------------------------------
// bit_reversal_reorder_buf
//   Ping-pong frame buffer that reorders FFT samples between natural and
//   bit-reversed order. One bank is filled while the other is streamed out.
//   Bit reversal is applied on the write side. The read side always walks the
//   addresses 0..N-1 in order, so out_group_idx is simply the read counter.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   di_en/di_rdy    input sample handshake; di_en while !di_rdy sets err_ovf
//   data_i          signed input sample (I_BW)
//   in_group_num    frame tag, latched when the frame closes
//   in_group_idx    sample index within frame; idx N-1 closes the frame
//   mode_bitrev     1: bit-reversed reorder, 0: natural pass-through
//   do_en/do_rdy    output sample handshake with downstream backpressure
//   data_o          sign-extended output sample (O_BW)
//   out_group_num   frame tag of presented sample
//   out_group_idx   output position in frame, ascending
//   err_ovf         sticky overflow flag, cleared only by rst
// ---------------------------------------------------------------------------
module bit_reversal_reorder_buf #(
    parameter int I_BW    = 14,
    parameter int O_BW    = 14,
    parameter int LOG2_N  = 10,
    parameter int GNUM_BW = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               di_en,
    output logic               di_rdy,
    input  logic [I_BW-1:0]    data_i,
    input  logic [GNUM_BW-1:0] in_group_num,
    input  logic [LOG2_N-1:0]  in_group_idx,
    input  logic               mode_bitrev,
    output logic               do_en,
    input  logic               do_rdy,
    output logic [O_BW-1:0]    data_o,
    output logic [GNUM_BW-1:0] out_group_num,
    output logic [LOG2_N-1:0]  out_group_idx,
    output logic               err_ovf
);
    localparam int N = 1 << LOG2_N;

    typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAINING} bank_st_t;
    typedef enum logic {RD_IDLE, RD_RUN} rd_st_t;

    function automatic logic [LOG2_N-1:0] bitrev(input logic [LOG2_N-1:0] v);
        logic [LOG2_N-1:0] r;
        for (int i = 0; i < LOG2_N; i++) r[i] = v[LOG2_N-1-i];
        return r;
    endfunction

    logic [I_BW-1:0]    mem [2][N];
    bank_st_t           bst [2];
    logic               bmode [2];
    logic [GNUM_BW-1:0] bgnum [2];
    logic               wb, rb;
    logic               live;      // low during reset and until the first edge after it

    logic               wr, wclose, wr_mode;
    logic [LOG2_N-1:0]  waddr;

    rd_st_t             rd_st, rd_nxt;
    logic [LOG2_N-1:0]  rd_cnt, rd_cnt_nxt, rd_addr;
    logic               issue, issue_last, start;
    logic               out_free, xfer;
    logic               out_last, out_bank;
    logic [I_BW-1:0]    rd_word;
    logic [O_BW-1:0]    rd_ext;

    // ---------------- write side ----------------
    assign di_rdy  = live && (bst[wb] == B_EMPTY || bst[wb] == B_FILLING);
    assign wr      = di_en && di_rdy;
    assign wclose  = wr && (&in_group_idx);
    // Mode is sampled on the first write into an empty bank and held for the frame.
    assign wr_mode = (bst[wb] == B_EMPTY) ? mode_bitrev : bmode[wb];
    assign waddr   = wr_mode ? bitrev(in_group_idx) : in_group_idx;

    always_ff @(posedge clk) begin
        if (wr) mem[wb][waddr] <= data_i;
    end

    // ---------------- read FSM ----------------
    // The output register is reloaded only when it is empty or being consumed
    // this cycle, so a stall simply freezes both the register and the counter.
    assign out_free = !do_en || do_rdy;
    assign xfer     = do_en && do_rdy;

    always_comb begin
        rd_nxt     = rd_st;
        rd_cnt_nxt = rd_cnt;
        rd_addr    = rd_cnt;
        issue      = 1'b0;
        start      = 1'b0;
        case (rd_st)
            RD_IDLE: begin
                // Address 0 is issued in the same cycle the bank is seen FULL,
                // giving first do_en two cycles after the closing write.
                if (bst[rb] == B_FULL && out_free) begin
                    issue      = 1'b1;
                    start      = 1'b1;
                    rd_addr    = '0;
                    rd_cnt_nxt = LOG2_N'(1);
                    rd_nxt     = RD_RUN;
                end
            end
            RD_RUN: begin
                if (out_free) begin
                    issue      = 1'b1;
                    rd_cnt_nxt = rd_cnt + 1'b1;
                    if (&rd_cnt) rd_nxt = RD_IDLE;
                end
            end
        endcase
    end

    assign issue_last = issue && (&rd_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_st  <= RD_IDLE;
            rd_cnt <= '0;
        end else begin
            rd_st  <= rd_nxt;
            rd_cnt <= rd_cnt_nxt;
        end
    end

    assign rd_word = mem[rb][rd_addr];
    assign rd_ext  = O_BW'($signed(rd_word));

    // ---------------- bank state, pointers, output register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                bst[b]   <= B_EMPTY;
                bmode[b] <= 1'b0;
                bgnum[b] <= '0;
            end
            wb            <= 1'b0;
            rb            <= 1'b0;
            live          <= 1'b0;
            err_ovf       <= 1'b0;
            do_en         <= 1'b0;
            data_o        <= '0;
            out_group_num <= '0;
            out_group_idx <= '0;
            out_last      <= 1'b0;
            out_bank      <= 1'b0;
        end else begin
            live <= 1'b1;
            if (di_en && !di_rdy) err_ovf <= 1'b1;

            if (wr) begin
                if (bst[wb] == B_EMPTY) begin
                    bst[wb]   <= B_FILLING;
                    bmode[wb] <= mode_bitrev;
                end
                if (wclose) begin
                    bst[wb]   <= B_FULL;
                    bgnum[wb] <= in_group_num;
                    wb        <= ~wb;
                end
            end

            // The bank read here is never the write bank, so these never collide.
            if (start)      bst[rb] <= B_DRAINING;
            if (issue_last) rb      <= ~rb;
            // Bank is released only once its last word has left the output register.
            if (xfer && out_last) bst[out_bank] <= B_EMPTY;

            if (issue) begin
                do_en         <= 1'b1;
                data_o        <= rd_ext;
                out_group_num <= bgnum[rb];
                out_group_idx <= rd_addr;
                out_last      <= issue_last;
                out_bank      <= rb;
            end else if (do_rdy) begin
                do_en <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_bit_reversal_reorder_buf.sv
module tb_bit_reversal_reorder_buf;
    localparam int I_BW = 14, O_BW = 16, LOG2_N = 3, GNUM_BW = 7;
    localparam int N = 1 << LOG2_N;

    logic               clk = 1'b0, rst = 1'b1;
    logic               di_en = 1'b0, di_rdy;
    logic [I_BW-1:0]    data_i = '0;
    logic [GNUM_BW-1:0] in_group_num = '0;
    logic [LOG2_N-1:0]  in_group_idx = '0;
    logic               mode_bitrev = 1'b0;
    logic               do_en, do_rdy = 1'b1;
    logic [O_BW-1:0]    data_o;
    logic [GNUM_BW-1:0] out_group_num;
    logic [LOG2_N-1:0]  out_group_idx;
    logic               err_ovf;

    bit_reversal_reorder_buf #(.I_BW(I_BW), .O_BW(O_BW), .LOG2_N(LOG2_N), .GNUM_BW(GNUM_BW)) dut (
        .clk(clk), .rst(rst), .di_en(di_en), .di_rdy(di_rdy), .data_i(data_i),
        .in_group_num(in_group_num), .in_group_idx(in_group_idx), .mode_bitrev(mode_bitrev),
        .do_en(do_en), .do_rdy(do_rdy), .data_o(data_o), .out_group_num(out_group_num),
        .out_group_idx(out_group_idx), .err_ovf(err_ovf));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [O_BW-1:0]    d;
        logic [GNUM_BW-1:0] g;
        logic [LOG2_N-1:0]  k;
    } exp_t;

    exp_t expq[$];
    int   compared = 0, mismatched = 0;
    int   closed = 0, drained = 0;    // frames accepted / frames fully read out
    int   cyc = 0, close_cyc = 0, first_cyc = 0, last_cyc = 0, last_gap = 0;
    bit   have_last = 0;
    int   frm [N];
    int   rdy_mode = 0, ph = 0;       // 0: always 1, 1: 1,0,0 pattern, 2: random, 3: always 0

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: do_rdy = 1'b1;
            1: begin do_rdy = (ph == 0); ph = (ph + 1) % 3; end
            2: do_rdy = 1'($urandom_range(0, 1));
            default: do_rdy = 1'b0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference bit reversal by repeated halving.
    function automatic int bitrev(input int k);
        int r = 0, x = k;
        for (int b = 0; b < LOG2_N; b++) begin r = r * 2 + x % 2; x = x / 2; end
        return r;
    endfunction

    function automatic int rand_val();
        return int'($urandom_range(0, 16383)) - 8192;
    endfunction

    // Output monitor / scoreboard
    logic        stall_prev = 1'b0;
    logic [26:0] hold_val = '0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                chk("stall_hold", {5'b0, do_en, data_o, out_group_num, out_group_idx}, {5'b0, hold_val});
            if (do_en && do_rdy) begin
                if (expq.size() == 0) chk("spurious_out", 32'd1, 32'd0);
                else begin
                    e = expq.pop_front();
                    chk("data_o", 32'(data_o), 32'(e.d));
                    chk("out_group_num", 32'(out_group_num), 32'(e.g));
                    chk("out_group_idx", 32'(out_group_idx), 32'(e.k));
                end
                if (out_group_idx == 0) begin
                    first_cyc = cyc;
                    if (have_last) last_gap = cyc - last_cyc;
                end
                if (&out_group_idx) begin
                    last_cyc  = cyc;
                    have_last = 1'b1;
                    drained++;
                end
            end
            stall_prev = do_en && !do_rdy;
            hold_val   = {do_en, data_o, out_group_num, out_group_idx};
        end
    end

    task automatic send(input int idx, input int val, input int g, input bit m, input bit may_wait);
        exp_t e;
        int   n = 0;
        @(posedge clk); #1;
        if (may_wait)
            while ((closed - drained) >= 2 && n < 400) begin
                di_en = 1'b0; @(posedge clk); #1; n++;
            end
        if (n >= 400) chk("wait_rdy_timeout", 32'd0, 32'd1);
        chk("di_rdy", 32'(di_rdy), 32'((closed - drained) < 2));
        di_en = 1'b1; data_i = I_BW'(val); in_group_idx = LOG2_N'(idx);
        in_group_num = GNUM_BW'(g); mode_bitrev = m;
        if ((closed - drained) < 2) begin
            frm[idx] = val;
            if (idx == N - 1) begin
                for (int k = 0; k < N; k++) begin
                    e.d = O_BW'(frm[m ? bitrev(k) : k]);
                    e.g = GNUM_BW'(g);
                    e.k = LOG2_N'(k);
                    expq.push_back(e);
                end
                closed++;
                close_cyc = cyc;
            end
        end
    endtask

    // Full frame; rnd shuffles the order, randomizes data and overwrites one index.
    task automatic send_frame(input int g, input bit m, input bit rnd, input bit may_wait);
        int ord [N];
        int t, j;
        for (int i = 0; i < N; i++) ord[i] = i;
        if (rnd)
            for (int i = N - 2; i > 0; i--) begin
                j = int'($urandom_range(0, i)); t = ord[i]; ord[i] = ord[j]; ord[j] = t;
            end
        for (int i = 0; i < N - 1; i++) send(ord[i], rnd ? rand_val() : ord[i], g, m, may_wait);
        if (rnd) send(ord[0], rand_val(), g, m, may_wait);
        send(N - 1, rnd ? rand_val() : N - 1, g, m, may_wait);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        di_en = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((expq.size() != 0 || closed != drained) && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        chk("drain_done", 32'(expq.size() == 0 && closed == drained), 32'd1);
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_do_en", 32'(do_en), 0);
        chk("rst_di_rdy", 32'(di_rdy), 0);
        chk("rst_data_o", 32'(data_o), 0);
        chk("rst_gnum", 32'(out_group_num), 0);
        chk("rst_gidx", 32'(out_group_idx), 0);
        chk("rst_err_ovf", 32'(err_ovf), 0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0; #1;
        chk("di_rdy_before_edge", 32'(di_rdy), 0);

        // 1: bit-reversed, data = idx
        rdy_mode = 0;
        send_frame(1, 1'b1, 1'b0, 1'b1);
        idle();
        wait_drain();
        chk("latency_bitrev", 32'(first_cyc - close_cyc), 32'd2);

        // 2: natural order
        send_frame(2, 1'b0, 1'b0, 1'b1);
        idle();
        wait_drain();
        chk("latency_natural", 32'(first_cyc - close_cyc), 32'd2);

        // 3: back-to-back frames 5 and 6
        send_frame(5, 1'b1, 1'b0, 1'b0);
        send_frame(6, 1'b1, 1'b1, 1'b0);
        idle();
        wait_drain();
        chk("frame_gap_le2", 32'(last_gap <= 2), 32'd1);

        // 4: downstream stalls 1,0,0
        rdy_mode = 1;
        send_frame(9, 1'b1, 1'b1, 1'b1);
        send_frame(10, 1'b0, 1'b1, 1'b1);
        idle();
        wait_drain();
        chk("no_ovf_yet", 32'(err_ovf), 0);

        // 5: do_rdy held low, third frame overflows
        rdy_mode = 3;
        send_frame(11, 1'b1, 1'b1, 1'b1);
        send_frame(12, 1'b0, 1'b1, 1'b1);
        chk("ovf_before_3rd", 32'(err_ovf), 0);
        send_frame(13, 1'b1, 1'b1, 1'b0);
        idle();
        chk("ovf_set", 32'(err_ovf), 1);
        rdy_mode = 0;
        wait_drain();
        chk("ovf_sticky", 32'(err_ovf), 1);

        // Randomized frames with random backpressure
        rdy_mode = 2;
        for (int f = 0; f < 4; f++) send_frame(30 + f, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
        idle();
        wait_drain();

        // 6: reset mid-drain and mid-fill
        rdy_mode = 1;
        send_frame(20, 1'b1, 1'b1, 1'b1);
        send(0, 5, 21, 1'b1, 1'b1);
        send(1, 6, 21, 1'b1, 1'b1);
        send(2, 7, 21, 1'b1, 1'b1);
        @(posedge clk); #3;
        rst = 1'b1; #1;
        chk("async_rst_do_en", 32'(do_en), 0);
        chk("async_rst_err_ovf", 32'(err_ovf), 0);
        chk("async_rst_data_o", 32'(data_o), 0);
        di_en = 1'b0;
        expq.delete();
        closed = drained;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0; #1;
        chk("di_rdy_after_rst", 32'(di_rdy), 0);
        rdy_mode = 0;
        send_frame(22, 1'b1, 1'b1, 1'b1);
        idle();
        wait_drain();
        chk("err_ovf_final", 32'(err_ovf), 0);
        chk("do_en_idle", 32'(do_en), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
